// File: rtl/line_cache_filler.sv
`default_nettype none
// ============================================================================
// Module      : line_cache_filler
// Description : Fetches one display row from SDRAM in fixed-length bursts and
//               writes it into one half of the line cache.
// Revision    : 1.0 - initial release
// ============================================================================
module line_cache_filler #(
    parameter int WORDS_PER_ROW = 640,
    parameter int BURST_LEN     = 8,
    parameter int LINE_BUDGET   = 1688
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        g_req,
    output logic        g_ack,
    input  logic        g_cache_row,
    input  logic [9:0]  g_sdram_row,
    output logic        sd_req,
    input  logic        sd_ready,
    output logic [19:0] sd_addr,
    input  logic        sd_rdata_valid,
    input  logic [15:0] sd_rdata,
    output logic        wr_en,
    output logic [10:0] wr_address,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        late
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CYC_W  = $clog2(LINE_BUDGET + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [10:0]       ROW_END   = 11'(WORDS_PER_ROW);
    localparam logic [CYC_W-1:0]  CYC_MAX   = CYC_W'(LINE_BUDGET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic                crow_q,       crow_d;
    logic [9:0]          srow_q,       srow_d;
    logic [9:0]          col_q,        col_d;
    logic [BEAT_W-1:0]   beat_q,       beat_d;
    logic [CYC_W-1:0]    cyc_q,        cyc_d;
    logic                g_ack_q,      g_ack_d;
    logic                wr_en_q,      wr_en_d;
    logic [10:0]         wr_address_q, wr_address_d;
    logic [15:0]         wr_data_q,    wr_data_d;
    logic                late_q,       late_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            crow_q       <= 1'b0;
            srow_q       <= 10'd0;
            col_q        <= 10'd0;
            beat_q       <= '0;
            cyc_q        <= '0;
            g_ack_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_address_q <= 11'd0;
            wr_data_q    <= 16'd0;
            late_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            crow_q       <= crow_d;
            srow_q       <= srow_d;
            col_q        <= col_d;
            beat_q       <= beat_d;
            cyc_q        <= cyc_d;
            g_ack_q      <= g_ack_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            late_q       <= late_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        crow_d       = crow_q;
        srow_d       = srow_q;
        col_d        = col_q;
        beat_d       = beat_q;
        cyc_d        = cyc_q;
        g_ack_d      = g_ack_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        late_d       = late_q;

        // Budget counter runs only while the fetch is in flight and saturates.
        if ((state_q == CMD || state_q == DATA) && cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
        if ((state_q == CMD || state_q == DATA) && cyc_d == CYC_MAX) begin
            late_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (g_req != g_ack_q) begin
                    crow_d  = g_cache_row;
                    srow_d  = g_sdram_row;
                    col_d   = 10'd0;
                    cyc_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (sd_ready) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sd_rdata_valid) begin
                    wr_en_d      = 1'b1;
                    wr_address_d = {crow_q, col_q};
                    wr_data_d    = sd_rdata;
                    col_d        = col_q + 10'd1;
                    beat_d       = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = (({1'b0, col_q} + 11'd1) == ROW_END) ? DONE : CMD;
                    end
                end
            end
            DONE: begin
                // Ack lands after the final write strobe has been presented.
                g_ack_d = ~g_ack_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sd_req     = (state_q == CMD);
    assign sd_addr    = {srow_q, col_q};
    assign busy       = (state_q != IDLE);
    assign g_ack      = g_ack_q;
    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign late       = late_q;

endmodule
`default_nettype wire

// File: tb/tb_line_cache_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_cache_filler
// Description : Directed self-checking bench for line_cache_filler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_cache_filler;

    localparam int WORDS = 640;
    localparam int BL    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        g_req;
    logic        g_ack;
    logic        g_cache_row;
    logic [9:0]  g_sdram_row;
    logic        sd_req;
    logic        sd_ready;
    logic [19:0] sd_addr;
    logic        sd_rdata_valid;
    logic [15:0] sd_rdata;
    logic        wr_en;
    logic [10:0] wr_address;
    logic [15:0] wr_data;
    logic        busy;
    logic        late;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_cache_filler #(
        .WORDS_PER_ROW (640),
        .BURST_LEN     (8),
        .LINE_BUDGET   (1688)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .g_req          (g_req),
        .g_ack          (g_ack),
        .g_cache_row    (g_cache_row),
        .g_sdram_row    (g_sdram_row),
        .sd_req         (sd_req),
        .sd_ready       (sd_ready),
        .sd_addr        (sd_addr),
        .sd_rdata_valid (sd_rdata_valid),
        .sd_rdata       (sd_rdata),
        .wr_en          (wr_en),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .busy           (busy),
        .late           (late)
    );

    // One complete fetch against an SDRAM model that returns word == column.
    // Called at a negedge; returns at the negedge where g_ack is seen toggled.
    task automatic run_fetch(input logic crow, input logic [9:0] srow,
                             input int stall_pct, input int hold,
                             input bit inject, input int abort_at);
        int   beats_left = 0;
        int   writes     = 0;
        int   sent       = 0;
        int   cmds       = 0;
        int   held       = 0;
        int   cyc        = 0;
        int   last_wr    = -100;
        int   cmd_col    = 0;
        logic exp_wr     = 1'b0;
        logic prev_ack;
        bit   done       = 0;
        prev_ack    = g_ack;
        g_cache_row = crow;
        g_sdram_row = srow;
        g_req       = ~g_req;
        while (!done) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (wr_en !== exp_wr) begin
                n_bad++;
                $display("FAIL wr_en_strobe cyc=%0d got=%b want=%b", cyc, wr_en, exp_wr);
            end
            if (wr_en === 1'b1) begin
                n_cmp++;
                if (wr_address !== {crow, 10'(writes)} || wr_data !== 16'(writes)) begin
                    n_bad++;
                    $display("FAIL write_beat idx=%0d got addr=%h data=%h want addr=%h data=%h",
                             writes, wr_address, wr_data, {crow, 10'(writes)}, 16'(writes));
                end
                writes++;
                last_wr = cyc;
            end
            exp_wr = 1'b0;
            if (g_ack !== prev_ack) begin
                n_cmp++;
                if (writes != WORDS || cmds != WORDS / BL || cyc - last_wr != 1) begin
                    n_bad++;
                    $display("FAIL fetch_end got writes=%0d cmds=%0d ack_delay=%0d want 640 80 1",
                             writes, cmds, cyc - last_wr);
                end
                if (stall_pct == 0 && hold == 0 && !inject) begin
                    n_cmp++;
                    if (cyc != 722) begin
                        n_bad++;
                        $display("FAIL fetch_time got=%0d want=722", cyc);
                    end
                end
                sd_ready       = 1'b0;
                sd_rdata_valid = 1'b0;
                done = 1;
            end else if (cyc > 6000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fetch_timeout got writes=%0d want=640", writes);
                sd_ready       = 1'b0;
                sd_rdata_valid = 1'b0;
                done = 1;
            end else if (abort_at >= 0 && writes == abort_at) begin
                reset = 1'b1;
                #1;
                n_cmp++;
                if (wr_en !== 1'b0 || sd_req !== 1'b0 || g_ack !== 1'b0 ||
                    busy !== 1'b0 || late !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_reset got wr_en=%b sd_req=%b g_ack=%b busy=%b late=%b want all 0",
                             wr_en, sd_req, g_ack, busy, late);
                end
                sd_ready       = 1'b0;
                sd_rdata_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                done = 1;
            end else begin
                sd_rdata_valid = 1'b0;
                if (beats_left > 0) begin
                    if (int'($urandom_range(99)) >= stall_pct) begin
                        sd_rdata_valid = 1'b1;
                        sd_rdata       = 16'(sent);
                        sent++;
                        beats_left--;
                        exp_wr = 1'b1;
                    end
                end else if (inject && sd_req === 1'b1 && cmds == 0) begin
                    sd_rdata_valid = 1'b1;
                    sd_rdata       = 16'hBEEF;
                end
                sd_ready = 1'b0;
                if (sd_req === 1'b1 && beats_left == 0) begin
                    n_cmp++;
                    if (sd_addr !== {srow, 10'(cmd_col)}) begin
                        n_bad++;
                        $display("FAIL cmd_addr got=%h want=%h", sd_addr, {srow, 10'(cmd_col)});
                    end
                    if (cmds == 0 && held < hold) begin
                        held++;
                    end else if (int'($urandom_range(99)) >= stall_pct) begin
                        sd_ready   = 1'b1;
                        beats_left = BL;
                        cmds++;
                        cmd_col += BL;
                    end
                end
            end
        end
    endtask

    task automatic idle_quiet(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            sd_rdata_valid = stray;
            sd_rdata       = 16'h5A5A;
            @(negedge clk);
            n_cmp++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_quiet got wr_en=%b busy=%b want 0 0", wr_en, busy);
            end
        end
        sd_rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; g_req = 1'b0; g_cache_row = 1'b0; g_sdram_row = 10'd0;
        sd_ready = 1'b0; sd_rdata_valid = 1'b0; sd_rdata = 16'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (g_ack !== 1'b0 || sd_req !== 1'b0 || wr_en !== 1'b0 || late !== 1'b0 ||
            busy !== 1'b0 || sd_addr !== 20'd0 || wr_address !== 11'd0 || wr_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state got ack=%b req=%b wr=%b late=%b busy=%b addr=%h wa=%h wd=%h want zeros",
                     g_ack, sd_req, wr_en, late, busy, sd_addr, wr_address, wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal_fetch();
        run_fetch(1'b1, 10'h155, 0, 0, 0, -1);
        n_cmp++;
        if (g_ack !== 1'b1 || late !== 1'b0) begin
            n_bad++;
            $display("FAIL ideal_done got ack=%b late=%b want 1 0", g_ack, late);
        end
    endtask

    task automatic test_random_stalls();
        run_fetch(1'b0, 10'h0F3, 30, 0, 0, -1);
        n_cmp++;
        if (g_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_done got ack=%b want 0", g_ack);
        end
    endtask

    task automatic test_stray_beats();
        idle_quiet(6, 1'b1);
        run_fetch(1'b1, 10'h3FF, 0, 6, 1, -1);
        n_cmp++;
        if (g_ack !== 1'b1 || late !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_done got ack=%b late=%b want 1 0", g_ack, late);
        end
    endtask

    task automatic test_back_to_back();
        run_fetch(1'b0, 10'h001, 0, 0, 0, -1);
        run_fetch(1'b1, 10'h002, 0, 0, 0, -1);
        run_fetch(1'b0, 10'h003, 0, 0, 0, -1);
        idle_quiet(20, 1'b0);
    endtask

    task automatic test_late();
        run_fetch(1'b1, 10'h2C4, 0, 2000, 0, -1);
        n_cmp++;
        if (g_ack !== 1'b1 || late !== 1'b1) begin
            n_bad++;
            $display("FAIL late_done got ack=%b late=%b want 1 1", g_ack, late);
        end
        idle_quiet(10, 1'b0);
        n_cmp++;
        if (late !== 1'b1) begin
            n_bad++;
            $display("FAIL late_sticky got=%b want=1", late);
        end
    endtask

    task automatic test_reset_abort();
        run_fetch(1'b0, 10'h123, 0, 0, 0, 300);
        idle_quiet(12, 1'b1);
        run_fetch(1'b0, 10'h2AA, 0, 0, 0, -1);
        n_cmp++;
        if (g_ack !== 1'b1 || late !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_done got ack=%b late=%b want 1 0", g_ack, late);
        end
    endtask

    initial begin
        test_reset();
        test_ideal_fetch();
        test_random_stalls();
        test_stray_beats();
        test_back_to_back();
        test_late();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
